// File: rtl/ntt_pkg.sv
// Constants, per-beat mode bundle and modulus helpers shared by the Kyber/Dilithium
// butterfly datapath.
package ntt_pkg;

   localparam int Q_KYBER = 3329;
   localparam int Q_DIL   = 8380417;

   // Only the low product bits are ever used, so QINV is kept as a 32-bit pattern.
   localparam logic [31:0] QINV_KYBER = 32'hFFFF_F301;  // -3327
   localparam logic [31:0] QINV_DIL   = 32'd58728449;

   localparam logic ALGO_KYBER = 1'b0;

   typedef struct packed {
      logic intt;
      logic algo;
      logic skip;
   } bf_mode_t;

   function automatic logic [31:0] qinv_of(input logic algo);
      return algo ? QINV_DIL : QINV_KYBER;
   endfunction

   function automatic logic signed [63:0] q_of(input logic algo);
      return algo ? 64'(Q_DIL) : 64'(Q_KYBER);
   endfunction

endpackage

// File: rtl/bfu_lane.sv
// Single-lane five-stage butterfly datapath; mode bits for each stage are supplied by the
// owner of the valid/mode chain, and every register holds while i_en is low.
module bfu_lane
   import ntt_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_en,
   input  logic               i_intt_s0,
   input  logic               i_algo_s1,
   input  logic               i_algo_s2,
   input  logic               i_algo_s3,
   input  logic               i_intt_s4,
   input  logic               i_skip_s4,
   input  logic signed [31:0] i_a,
   input  logic signed [31:0] i_b,
   input  logic signed [31:0] i_tw,
   output logic signed [31:0] o_a,
   output logic signed [31:0] o_b
);

   logic signed [31:0] r_s0_a, r_s0_b, r_s0_s, r_s0_m, r_s0_tw;
   logic signed [31:0] r_s1_a, r_s1_b, r_s1_s;
   logic signed [63:0] r_s1_p;
   logic signed [31:0] r_s2_a, r_s2_b, r_s2_s;
   logic signed [63:0] r_s2_p, r_s2_t;
   logic signed [31:0] r_s3_a, r_s3_b, r_s3_s, r_s3_r;
   logic signed [31:0] r_s4_a, r_s4_b;

   logic signed [31:0] w_s0_s, w_s0_d, w_s0_m;
   logic signed [63:0] w_s1_m, w_s1_tw, w_s1_p;
   logic signed [31:0] w_s1_s;
   logic        [31:0] w_s2_pq;
   logic signed [63:0] w_s2_t;
   logic signed [31:0] w_s2_s;
   logic signed [63:0] w_s3_num, w_s3_sh;
   logic signed [31:0] w_s3_r;
   logic signed [31:0] w_s4_a, w_s4_b;

   // S0: the multiplier operand is b for NTT and (b - a) for INTT.
   assign w_s0_s = i_b + i_a;
   assign w_s0_d = i_b - i_a;
   assign w_s0_m = i_intt_s0 ? w_s0_d : i_b;

   assign w_s1_m  = {{32{r_s0_m[31]}}, r_s0_m};
   assign w_s1_tw = {{32{r_s0_tw[31]}}, r_s0_tw};
   assign w_s1_p  = w_s1_m * w_s1_tw;
   assign w_s1_s  = (i_algo_s1 == ALGO_KYBER && r_s0_s >= Q_KYBER) ? r_s0_s - Q_KYBER : r_s0_s;

   // Kyber keeps 16 low bits of p*QINV, Dilithium 32; both sign-extended.
   assign w_s2_pq = r_s1_p[31:0] * qinv_of(i_algo_s2);
   assign w_s2_t  = i_algo_s2 ? {{32{w_s2_pq[31]}}, w_s2_pq}
                              : {{48{w_s2_pq[15]}}, w_s2_pq[15:0]};
   assign w_s2_s  = (i_algo_s2 == ALGO_KYBER && r_s1_s <= -Q_KYBER) ? r_s1_s + Q_KYBER : r_s1_s;

   assign w_s3_num = r_s2_p - r_s2_t * q_of(i_algo_s3);
   assign w_s3_sh  = i_algo_s3 ? (w_s3_num >>> 32) : (w_s3_num >>> 16);
   assign w_s3_r   = w_s3_sh[31:0];

   always_comb begin
      w_s4_a = r_s3_a + r_s3_r;
      w_s4_b = r_s3_a - r_s3_r;
      if (i_skip_s4) begin
         w_s4_a = r_s3_a;
         w_s4_b = r_s3_b;
      end else if (i_intt_s4) begin
         w_s4_a = r_s3_s;
         w_s4_b = r_s3_r;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s0_a  <= '0;
         r_s0_b  <= '0;
         r_s0_s  <= '0;
         r_s0_m  <= '0;
         r_s0_tw <= '0;
         r_s1_a  <= '0;
         r_s1_b  <= '0;
         r_s1_s  <= '0;
         r_s1_p  <= '0;
         r_s2_a  <= '0;
         r_s2_b  <= '0;
         r_s2_s  <= '0;
         r_s2_p  <= '0;
         r_s2_t  <= '0;
         r_s3_a  <= '0;
         r_s3_b  <= '0;
         r_s3_s  <= '0;
         r_s3_r  <= '0;
         r_s4_a  <= '0;
         r_s4_b  <= '0;
      end else if (i_en) begin
         r_s0_a  <= i_a;
         r_s0_b  <= i_b;
         r_s0_s  <= w_s0_s;
         r_s0_m  <= w_s0_m;
         r_s0_tw <= i_tw;
         r_s1_a  <= r_s0_a;
         r_s1_b  <= r_s0_b;
         r_s1_s  <= w_s1_s;
         r_s1_p  <= w_s1_p;
         r_s2_a  <= r_s1_a;
         r_s2_b  <= r_s1_b;
         r_s2_s  <= w_s2_s;
         r_s2_p  <= r_s1_p;
         r_s2_t  <= w_s2_t;
         r_s3_a  <= r_s2_a;
         r_s3_b  <= r_s2_b;
         r_s3_s  <= r_s2_s;
         r_s3_r  <= w_s3_r;
         r_s4_a  <= w_s4_a;
         r_s4_b  <= w_s4_b;
      end
   end

   assign o_a = r_s4_a;
   assign o_b = r_s4_b;

endmodule

// File: rtl/bfu_lanes.sv
// LANES lockstep butterflies behind one valid/ready handshake; the valid, tag and mode
// chain lives here so every lane sees the same per-beat mode.
module bfu_lanes
   import ntt_pkg::*;
#(
   parameter int unsigned LANES = 2,
   parameter int unsigned TAGW  = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_intt,
   input  logic                  i_algo,
   input  logic                  i_skip,
   input  logic [TAGW-1:0]       i_tag,
   input  logic [32*LANES-1:0]   i_a,
   input  logic [32*LANES-1:0]   i_b,
   input  logic [32*LANES-1:0]   i_twiddle,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [TAGW-1:0]       o_tag,
   output logic [32*LANES-1:0]   o_a,
   output logic [32*LANES-1:0]   o_b
);

   logic                 w_adv;
   bf_mode_t             w_mode_in;
   logic [4:0]           r_vld;
   logic [4:0][TAGW-1:0] r_tag;
   bf_mode_t [2:0]       r_mode;
   logic                 r_intt3;
   logic                 r_skip3;

   // One global enable: the whole pipe moves unless a valid output is being refused.
   assign w_adv     = ~r_vld[4] | i_ready;
   assign o_ready   = w_adv;
   assign o_valid   = r_vld[4];
   assign o_tag     = r_tag[4];
   assign w_mode_in = '{intt: i_intt, algo: i_algo, skip: i_skip};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vld   <= '0;
         r_tag   <= '0;
         r_mode  <= '0;
         r_intt3 <= 1'b0;
         r_skip3 <= 1'b0;
      end else if (w_adv) begin
         r_vld   <= {r_vld[3:0], i_valid};
         r_tag   <= {r_tag[3:0], i_tag};
         r_mode  <= {r_mode[1:0], w_mode_in};
         r_intt3 <= r_mode[2].intt;
         r_skip3 <= r_mode[2].skip;
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      bfu_lane u_lane (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_en      (w_adv),
         .i_intt_s0 (i_intt),
         .i_algo_s1 (r_mode[0].algo),
         .i_algo_s2 (r_mode[1].algo),
         .i_algo_s3 (r_mode[2].algo),
         .i_intt_s4 (r_intt3),
         .i_skip_s4 (r_skip3),
         .i_a       (i_a[32*k +: 32]),
         .i_b       (i_b[32*k +: 32]),
         .i_tw      (i_twiddle[32*k +: 32]),
         .o_a       (o_a[32*k +: 32]),
         .o_b       (o_b[32*k +: 32])
      );
   end

endmodule

// File: tb/tb_bfu_lanes.sv
// Self-checking bench for bfu_lanes: directed literal beats plus a randomized handshake
// stream scored against a behavioural butterfly model.
module tb_bfu_lanes;

   localparam int unsigned LANES = 4;
   localparam int unsigned TAGW  = 8;
   localparam int unsigned W     = 32 * LANES;

   logic            clk = 1'b0;
   logic            rst;
   logic            i_valid, i_intt, i_algo, i_skip, i_ready;
   logic [TAGW-1:0] i_tag;
   logic [W-1:0]    i_a, i_b, i_tw;
   logic            o_ready, o_valid;
   logic [TAGW-1:0] o_tag;
   logic [W-1:0]    o_a, o_b;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   bfu_lanes #(.LANES(LANES), .TAGW(TAGW)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_intt    (i_intt),
      .i_algo    (i_algo),
      .i_skip    (i_skip),
      .i_tag     (i_tag),
      .i_a       (i_a),
      .i_b       (i_b),
      .i_twiddle (i_tw),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_tag     (o_tag),
      .o_a       (o_a),
      .o_b       (o_b)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference Montgomery reduction, written as the C model does it.
   function automatic int mont(input longint p, input bit algo);
      longint t;
      longint num;
      if (!algo) begin
         t   = longint'(shortint'(p * -3327));
         num = p - t * 3329;
         return int'(num >>> 16);
      end
      t   = longint'(int'(p * 58728449));
      num = p - t * 8380417;
      return int'(num >>> 32);
   endfunction

   function automatic void bf(input int a, input int b, input int tw, input bit intt,
                              input bit algo, input bit skip, output int oa, output int ob);
      int s;
      int d;
      int r;
      if (skip) begin
         oa = a;
         ob = b;
      end else if (!intt) begin
         r  = mont(longint'(b) * longint'(tw), algo);
         oa = a + r;
         ob = a - r;
      end else begin
         s = b + a;
         d = b - a;
         if (!algo) begin
            if (s >= 3329) s = s - 3329;
            if (s <= -3329) s = s + 3329;
         end
         oa = s;
         ob = mont(longint'(d) * longint'(tw), algo);
      end
   endfunction

   function automatic void model_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [W-1:0] tw, input bit intt, input bit algo,
                                      input bit skip, output logic [W-1:0] oa,
                                      output logic [W-1:0] ob);
      int la;
      int lb;
      for (int k = 0; k < LANES; k++) begin
         bf(int'(a[32*k +: 32]), int'(b[32*k +: 32]), int'(tw[32*k +: 32]), intt, algo, skip,
            la, lb);
         oa[32*k +: 32] = la;
         ob[32*k +: 32] = lb;
      end
   endfunction

   function automatic longint lane(input logic [W-1:0] v, input int k);
      return longint'($signed(v[32*k +: 32]));
   endfunction

   // Scoreboard: expected beats in order, each with the count of pipeline advances it has seen.
   logic [W-1:0]    q_a[$];
   logic [W-1:0]    q_b[$];
   logic [TAGW-1:0] q_t[$];
   int              q_adv[$];
   bit              after_rst = 1'b0;
   logic [W-1:0]    m_a, m_b;

   always @(negedge clk) begin
      if (rst) begin
         q_a.delete();
         q_b.delete();
         q_t.delete();
         q_adv.delete();
         after_rst = 1'b1;
      end else begin
         if (after_rst) begin
            chk("post_rst_o_valid", o_valid, 0);
            chk("post_rst_o_ready", o_ready, 1);
            chk("post_rst_o_zero", (o_a == '0) && (o_b == '0) && (o_tag == '0), 1);
            after_rst = 1'b0;
         end
         chk("o_ready_rule", o_ready, !o_valid || i_ready);
         if (o_valid) begin
            chk("stale_beat", q_a.size() != 0, 1);
            if (q_a.size() != 0) begin
               chk("latency_advances", q_adv[0], 5);
               chk("o_tag", o_tag, q_t[0]);
               for (int k = 0; k < LANES; k++) begin
                  chk($sformatf("o_a[%0d]", k), lane(o_a, k), lane(q_a[0], k));
                  chk($sformatf("o_b[%0d]", k), lane(o_b, k), lane(q_b[0], k));
               end
               if (i_ready) begin
                  void'(q_a.pop_front());
                  void'(q_b.pop_front());
                  void'(q_t.pop_front());
                  void'(q_adv.pop_front());
               end
            end
         end else if (q_a.size() != 0) begin
            chk("missing_beat", q_adv[0] < 5, 1);
         end
         if (o_ready) begin
            foreach (q_adv[i]) q_adv[i] = q_adv[i] + 1;
            if (i_valid) begin
               model_beat(i_a, i_b, i_tw, i_intt, i_algo, i_skip, m_a, m_b);
               q_a.push_back(m_a);
               q_b.push_back(m_b);
               q_t.push_back(i_tag);
               q_adv.push_back(1);
            end
         end
      end
   end

   task automatic set_beat(input int a, input int b, input int tw, input bit intt,
                           input bit algo, input bit skip, input logic [TAGW-1:0] tag);
      for (int k = 0; k < LANES; k++) begin
         i_a[32*k +: 32]  = a;
         i_b[32*k +: 32]  = b;
         i_tw[32*k +: 32] = tw;
      end
      i_intt = intt;
      i_algo = algo;
      i_skip = skip;
      i_tag  = tag;
   endtask

   function automatic int rand_coef(input bit algo);
      int q;
      q = algo ? 8380417 : 3329;
      if ($urandom_range(0, 7) == 0) return int'($urandom);
      return int'($urandom_range(0, 4 * q)) - 2 * q;
   endfunction

   task automatic set_rand_beat(input logic [TAGW-1:0] tag);
      int q;
      i_intt = 1'($urandom_range(0, 1));
      i_algo = 1'($urandom_range(0, 1));
      i_skip = ($urandom_range(0, 3) == 0);
      i_tag  = tag;
      q = i_algo ? 8380417 : 3329;
      for (int k = 0; k < LANES; k++) begin
         i_a[32*k +: 32]  = rand_coef(i_algo);
         i_b[32*k +: 32]  = rand_coef(i_algo);
         i_tw[32*k +: 32] = int'($urandom_range(0, q - 1));
      end
   endtask

   int           oa, ob;
   int           n_acc;
   int           cyc;
   logic [W-1:0]    hold_a;
   logic [TAGW-1:0] hold_t;

   initial begin
      rst     = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      set_beat(0, 0, 0, 1'b0, 1'b0, 1'b0, '0);

      // Pin the model to hand-computed butterflies.
      bf(10, 1, 4193792, 1'b0, 1'b1, 1'b0, oa, ob);
      chk("model_dil_ntt_a", oa, 11);
      chk("model_dil_ntt_b", ob, 9);
      bf(5, 1, 2285, 1'b0, 1'b0, 1'b0, oa, ob);
      chk("model_kyb_ntt_a", oa, 6);
      chk("model_kyb_ntt_b", ob, 4);
      bf(3000, 1000, 2285, 1'b1, 1'b0, 1'b0, oa, ob);
      chk("model_kyb_intt_a", oa, 671);
      chk("model_kyb_intt_b", ob, 1329);
      bf(-7, 123456, 99, 1'b1, 1'b1, 1'b1, oa, ob);
      chk("model_skip_a", oa, -7);
      chk("model_skip_b", ob, 123456);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_o_valid", o_valid, 0);
      chk("reset_o_ready", o_ready, 1);

      // Dilithium NTT, exact 5-cycle latency.
      set_beat(10, 1, 4193792, 1'b0, 1'b1, 1'b0, 8'h11);
      i_valid = 1'b1;
      @(posedge clk); #1 i_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("dil_not_early", o_valid, 0);
      @(posedge clk); #1;
      chk("dil_o_valid", o_valid, 1);
      chk("dil_o_tag", o_tag, 8'h11);
      chk("dil_o_a0", lane(o_a, 0), 11);
      chk("dil_o_b3", lane(o_b, LANES - 1), 9);

      // Kyber NTT followed directly by Kyber INTT.
      set_beat(5, 1, 2285, 1'b0, 1'b0, 1'b0, 8'h21);
      i_valid = 1'b1;
      @(posedge clk); #1;
      set_beat(3000, 1000, 2285, 1'b1, 1'b0, 1'b0, 8'h22);
      @(posedge clk); #1 i_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("kyb_ntt_o_a", lane(o_a, 0), 6);
      chk("kyb_ntt_o_b", lane(o_b, 1), 4);
      @(posedge clk); #1;
      chk("kyb_intt_tag", o_tag, 8'h22);
      chk("kyb_intt_o_a", lane(o_a, 2), 671);
      chk("kyb_intt_o_b", lane(o_b, 3), 1329);

      // Skip beat, then back-to-back beats cycling through every mode combination.
      set_beat(-7, 123456, 17, 1'b1, 1'b0, 1'b1, 8'h30);
      i_valid = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin
            chk("skip_tag", o_tag, 8'h30);
            chk("skip_o_a", lane(o_a, 0), -7);
            chk("skip_o_b", lane(o_b, 0), 123456);
         end
         set_rand_beat(8'(8'h31 + i));
         i_intt = i[0];
         i_algo = i[1];
         i_skip = i[2];
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1 chk("alt_drained", q_a.size(), 0);

      // Backpressure with a full pipe: nothing accepted, output held, then release.
      for (int i = 0; i < 5; i++) begin
         set_rand_beat(8'(8'h40 + i));
         i_valid = 1'b1;
         @(posedge clk); #1;
      end
      set_rand_beat(8'h45);
      i_ready = 1'b0;
      #1;
      hold_a = o_a;
      hold_t = o_tag;
      chk("bp_first_tag", o_tag, 8'h40);
      for (int j = 0; j < 3; j++) begin
         chk("bp_o_ready", o_ready, 0);
         chk("bp_o_valid", o_valid, 1);
         chk("bp_hold", (o_a == hold_a) && (o_tag == hold_t), 1);
         @(posedge clk); #1;
      end
      i_ready = 1'b1;
      @(posedge clk); #1 i_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 chk("bp_drained", q_a.size(), 0);

      // Random valid/ready stream with a one-cycle reset in the middle.
      n_acc = 0;
      cyc   = 0;
      while (n_acc < 10000 && cyc < 60000) begin
         set_rand_beat(8'(cyc));
         i_valid = ($urandom_range(0, 9) < 7);
         i_ready = ($urandom_range(0, 9) < 7);
         rst     = (cyc == 5000);
         #1;
         if (!rst && i_valid && o_ready) n_acc++;
         @(posedge clk); #1;
         cyc++;
      end
      rst = 1'b0;
      chk("random_beats_accepted", n_acc >= 10000, 1);
      i_valid = 1'b0;
      i_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1 chk("random_drained", q_a.size(), 0);

      // Reset while stalled with beats in flight; the next beat must take 5 cycles.
      i_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         set_rand_beat(8'(8'h60 + i));
         i_valid = 1'b1;
         @(posedge clk); #1;
      end
      chk("rst_stall_o_ready", o_ready, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst     = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b1;
      chk("rst_mid_o_valid", o_valid, 0);
      chk("rst_mid_o_ready", o_ready, 1);
      set_beat(5, 1, 2285, 1'b0, 1'b0, 1'b0, 8'h77);
      i_valid = 1'b1;
      @(posedge clk); #1 i_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("rst_next_not_early", o_valid, 0);
      @(posedge clk); #1;
      chk("rst_next_o_valid", o_valid, 1);
      chk("rst_next_o_tag", o_tag, 8'h77);
      chk("rst_next_o_a", lane(o_a, 0), 6);
      repeat (10) @(posedge clk);
      #1;
      chk("rst_no_stale", o_valid, 0);
      chk("final_drained", q_a.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/bfu_lanes.md
# bfu_lanes

Multi-lane, valid/ready-handshaked butterfly array for the NTT/INTT datapath, shared by Kyber (q=3329) and Dilithium (q=8380417). It is the parametrised successor of the single-lane butterfly: LANES butterflies run in lockstep, and mode bits and a user tag travel with each beat, so the mode can change on every beat. The pipeline stalls under downstream backpressure. It sits between the coefficient-RAM read port and the write-back path of the NTT controller.

## Interface
- LANES, 2, number of parallel butterflies (≥1)
- TAGW, 8, width of the sideband tag carried with each beat
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat this cycle
- i_intt  in  1  0 = NTT (Cooley-Tukey), 1 = INTT (Gentleman-Sande)
- i_algo  in  1  0 = Kyber, 1 = Dilithium
- i_skip  in  1  pass a/b through unmodified
- i_tag  in  TAGW  opaque tag, returned with the result
- i_a, i_b, i_twiddle  in  32*LANES  signed coefficients; lane k is bits [32k+31:32k]
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts the output
- o_tag  out  TAGW  tag of the output beat
- o_a, o_b  out  32*LANES  signed results, same packing as the inputs

## Operation
- A beat is accepted when i_valid & o_ready. Mode bits (intt, algo, skip) and the tag are captured with the data and apply only to that beat.
- NTT: p = b*tw (64-bit signed); r = mont(p); o_a = a+r; o_b = a−r.
- INTT: s = b+a; d = b−a.
  - Kyber only: if s ≥ q then s −= q; then, if s ≤ −q, s += q.
  - p = d*tw; o_a = s; o_b = mont(p).
- mont, Kyber: t = low 16 bits of p*(−3327), sign-extended; r = (p − t*3329) >>> 16.
- mont, Dilithium: t = low 32 bits of p*58728449; r = (p − t*8380417) >>> 32.
- mont yields |r| < q and r ≡ p·2^−R (mod q).
- Skip: o_a = a, o_b = b. Latency is the same as a normal beat.
- Sums and differences wrap at 32 bits. No output normalisation.
- All lanes share the same mode and tag.

## Timing
- Pipeline stages:
  - S0: input register, pre-add/sub.
  - S1: multiply, Kyber conditional subtract.
  - S2: multiply by QINV, Kyber conditional add.
  - S3: Montgomery subtract and shift.
  - S4: output register (add/sub for NTT).
- Latency is exactly 5 cycles from acceptance to o_valid while i_ready stays high.
- Throughput is one beat per cycle.
- Stall rule: advance = ~o_valid | i_ready, and o_ready = advance.
  - The whole pipeline, including per-stage valid bits, holds when advance = 0.
  - o_a, o_b, o_tag are stable while o_valid & ~i_ready.
- Bubbles: stage valid bits propagate. o_valid stays low for empty slots; empty slots do not block acceptance.
- Reset values: all stage valids = 0, o_valid = 0, o_a = o_b = 0, o_tag = 0.
  - o_ready = 1 in the cycle after reset deasserts.
  - Reset during a stall or with beats in flight discards every beat; none emerge afterwards.
- Simultaneous output accept and input accept in the same cycle: both complete, with no lost or duplicated beat.
- Mode changes between consecutive beats never corrupt either beat.

## Structure
- Shared package `ntt_pkg`: Q_KYBER, Q_DIL, QINV_KYBER, QINV_DIL, a `bf_mode_t` struct {intt, algo, skip}, and a `mont_reduce` function or its constants.
- One sub-module `bfu_lane`: the single-lane datapath with a stall enable (i_en). It is instantiated LANES times by generate.
- The top level owns the valid/tag/mode shift chain and the handshake.

## Test plan
- Dilithium NTT: a=10, b=1, tw=4193792 → o_a=11, o_b=9, 5 cycles after acceptance.
- Kyber NTT: a=5, b=1, tw=2285 → o_a=6, o_b=4. Kyber INTT: a=3000, b=1000, tw=2285 → o_a=671, o_b=1329.
- Back-to-back beats alternating algo/intt/skip every cycle with distinct tags; skip beat a=−7, b=123456 → o_a=−7, o_b=123456. Outputs appear in order, each matching its own mode.
- Backpressure: i_ready low for 3 cycles with 5 beats in flight → o_ready low, outputs held stable, no beat lost or duplicated on release.
- Random i_valid/i_ready over 10k beats with LANES=4 against a C-model `montgomery_reduce` → bit-exact, tags in order.
- Assert i_rst for one cycle mid-stream with beats in flight → o_valid=0 next cycle, no stale beat ever emerges, and the next accepted beat returns after 5 cycles.
